// File: rtl/matmul_operand_feeder.sv
// rtl/matmul_operand_feeder.sv - operand staging and diagonal skew feeder for a systolic multiply array
//
// Holds operand matrices A and B (one bus word per row write). A start pulses
// an accumulator clear, then streams skewed A lanes (array left edge) and
// B lanes (array top edge) one step per cycle, then pulses done.
//
// Optional build macro: MATMUL_FEEDER_TRANSPOSE_B_EN
//   defined   : B writes are column-wise (element e of wr_data_i -> B[e][wr_row_i])
//   undefined : B writes are row-wise    (element e of wr_data_i -> B[wr_row_i][e])
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_ni     in   synchronous active-low reset
//   wr_en_i    in   operand write strobe (honoured in IDLE/DONE only)
//   wr_sel_i   in   0 = A, 1 = B
//   wr_row_i   in   row (or B column when transposed) index
//   wr_data_i  in   element e at [e*DATA_WIDTH +: DATA_WIDTH]
//   start_i    in   begin a feed sequence (IDLE only)
//   n_dim_i    in   N-1, active a lanes
//   k_dim_i    in   K-1, inner dimension
//   m_dim_i    in   M-1, active b lanes
//   a_o        out  lane i -> array row i
//   b_o        out  lane j -> array column j
//   valid_o    out  a_o/b_o carry a feed step
//   clr_o      out  accumulator clear pulse
//   busy_o     out  high in CLEAR and FEED
//   done_o     out  pulse after the last feed step

module matmul_operand_feeder #(
   parameter  int DATA_WIDTH = 16,
   parameter  int BUS_WIDTH  = 64,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   localparam int DIM_W      = $clog2(MAX_DIM)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_en_i,
   input  logic                 wr_sel_i,
   input  logic [DIM_W-1:0]     wr_row_i,
   input  logic [BUS_WIDTH-1:0] wr_data_i,
   input  logic                 start_i,
   input  logic [DIM_W-1:0]     n_dim_i,
   input  logic [DIM_W-1:0]     k_dim_i,
   input  logic [DIM_W-1:0]     m_dim_i,
   output logic [BUS_WIDTH-1:0] a_o,
   output logic [BUS_WIDTH-1:0] b_o,
   output logic                 valid_o,
   output logic                 clr_o,
   output logic                 busy_o,
   output logic                 done_o
);

   // Feed steps run 0 .. K+MAX_DIM-2, at most 2*MAX_DIM-2.
   localparam int STEP_W = $clog2(2 * MAX_DIM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DONE
   } state_t;

   state_t                state;
   logic [STEP_W-1:0]     t;
   logic [DIM_W-1:0]      n_lat;
   logic [DIM_W-1:0]      k_lat;
   logic [DIM_W-1:0]      m_lat;
   logic [DATA_WIDTH-1:0] a_mem [MAX_DIM][MAX_DIM];
   logic [DATA_WIDTH-1:0] b_mem [MAX_DIM][MAX_DIM];

   logic [STEP_W-1:0]     last_step;
   logic [STEP_W-1:0]     nxt_step;
   logic [BUS_WIDTH-1:0]  a_nxt;
   logic [BUS_WIDTH-1:0]  b_nxt;

   assign last_step = STEP_W'(k_lat) + STEP_W'(MAX_DIM - 1);

   // Outputs are registered, so lanes are computed for the step that will be
   // presented next cycle: step 0 when leaving CLEAR, otherwise t+1.
   assign nxt_step = (state == S_CLEAR) ? '0 : t + STEP_W'(1);

   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         int d;
         d = int'(nxt_step) - i;
         // Signed offset: lanes outside the skew window stay exactly zero.
         if (d >= 0 && d <= int'(k_lat) && i <= int'(n_lat))
            a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = a_mem[i][d[DIM_W-1:0]];
         if (d >= 0 && d <= int'(k_lat) && i <= int'(m_lat))
            b_nxt[i*DATA_WIDTH +: DATA_WIDTH] = b_mem[d[DIM_W-1:0]][i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= S_IDLE;
         t       <= '0;
         n_lat   <= '0;
         k_lat   <= '0;
         m_lat   <= '0;
         a_o     <= '0;
         b_o     <= '0;
         valid_o <= 1'b0;
         clr_o   <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
               a_mem[r][c] <= '0;
               b_mem[r][c] <= '0;
            end
         end
      end else begin
         // Storage is frozen while a sequence is in flight.
         if (wr_en_i && (state == S_IDLE || state == S_DONE)) begin
            for (int e = 0; e < MAX_DIM; e++) begin
               if (!wr_sel_i)
                  a_mem[wr_row_i][e] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
               else
`ifdef MATMUL_FEEDER_TRANSPOSE_B_EN
                  b_mem[e][wr_row_i] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
`else
                  b_mem[wr_row_i][e] <= wr_data_i[e*DATA_WIDTH +: DATA_WIDTH];
`endif
            end
         end

         case (state)
            S_IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  n_lat  <= n_dim_i;
                  k_lat  <= k_dim_i;
                  m_lat  <= m_dim_i;
                  clr_o  <= 1'b1;
                  busy_o <= 1'b1;
                  state  <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               clr_o   <= 1'b0;
               valid_o <= 1'b1;
               a_o     <= a_nxt;
               b_o     <= b_nxt;
               t       <= '0;
               state   <= S_FEED;
            end
            S_FEED: begin
               if (t == last_step) begin
                  valid_o <= 1'b0;
                  a_o     <= '0;
                  b_o     <= '0;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  t   <= nxt_step;
                  a_o <= a_nxt;
                  b_o <= b_nxt;
               end
            end
            S_DONE: begin
               done_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// tb/tb_matmul_operand_feeder.sv - scoreboard bench for matmul_operand_feeder

module tb_matmul_operand_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic        wr_sel;
   logic [1:0]  wr_row;
   logic [63:0] wr_data;
   logic        start;
   logic [1:0]  n_dim, k_dim, m_dim;
   logic [63:0] a, b;
   logic        valid, clr, busy, done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
   } exp_t;

   exp_t        q[$];
   exp_t        hand_tab[7];
   logic [15:0] sa[4][4];
   logic [15:0] sb[4][4];

   always #5 clk = ~clk;

   matmul_operand_feeder dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wr_en_i   (wr_en),
      .wr_sel_i  (wr_sel),
      .wr_row_i  (wr_row),
      .wr_data_i (wr_data),
      .start_i   (start),
      .n_dim_i   (n_dim),
      .k_dim_i   (k_dim),
      .m_dim_i   (m_dim),
      .a_o       (a),
      .b_o       (b),
      .valid_o   (valid),
      .clr_o     (clr),
      .busy_o    (busy),
      .done_o    (done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int e0, input int e1, input int e2, input int e3);
      logic [15:0] v0, v1, v2, v3;
      v0 = 16'(e0); v1 = 16'(e1); v2 = 16'(e2); v3 = 16'(e3);
      return {v3, v2, v1, v0};
   endfunction

   function automatic logic [63:0] lane_a(input int t, input int n, input int k);
      logic [63:0] r = '0;
      for (int i = 0; i < 4; i++)
         if (t - i >= 0 && t - i <= k && i <= n) r[i*16 +: 16] = sa[i][t-i];
      return r;
   endfunction

   function automatic logic [63:0] lane_b(input int t, input int m, input int k);
      logic [63:0] r = '0;
      for (int j = 0; j < 4; j++)
         if (t - j >= 0 && t - j <= k && j <= m) r[j*16 +: 16] = sb[t-j][j];
      return r;
   endfunction

   task automatic clear_shadow();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            sa[r][c] = '0;
            sb[r][c] = '0;
         end
   endtask

   task automatic wr(input logic sel, input int row, input logic [63:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
      for (int e = 0; e < 4; e++) begin
         if (!sel) sa[row][e] = data[e*16 +: 16];
`ifdef MATMUL_FEEDER_TRANSPOSE_B_EN
         else sb[e][row] = data[e*16 +: 16];
`else
         else sb[row][e] = data[e*16 +: 16];
`endif
      end
   endtask

   // Issues a start, pushes the expected feed steps, and checks the
   // clr/valid/done timing. disturb injects a write and a second start mid-FEED.
   task automatic run(input int n, input int k, input int m, input bit hand, input bit disturb);
      int kk, off, vcnt, dcnt, doff;
      kk = k + 1; vcnt = 0; dcnt = 0; doff = -1;
      if (hand) for (int t = 0; t < 7; t++) q.push_back(hand_tab[t]);
      else for (int t = 0; t <= kk + 2; t++) q.push_back('{lane_a(t, n, k), lane_b(t, m, k)});
      @(negedge clk);
      start = 1'b1; n_dim = 2'(n); k_dim = 2'(k); m_dim = 2'(m);
      @(negedge clk);
      start = 1'b0; off = 1;
      chk("clr_at_c1", {63'b0, clr}, 64'd1);
      chk("busy_at_c1", {63'b0, busy}, 64'd1);
      chk("valid_at_c1", {63'b0, valid}, 64'd0);
      while (off < kk + 7) begin
         @(negedge clk);
         off++;
         if (disturb && off == 4) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = '1;
            start = 1'b1; n_dim = 2'd0; k_dim = 2'd0; m_dim = 2'd0;
         end else if (disturb && off == 5) begin
            wr_en = 1'b0; start = 1'b0;
         end
         if (valid) vcnt++;
         if (done) begin dcnt++; doff = off; end
      end
      chk("valid_count", 64'(vcnt), 64'(kk + 3));
      chk("done_count", 64'(dcnt), 64'd1);
      chk("done_offset", 64'(doff), 64'(kk + 5));
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid: got a=%h b=%h expected no feed step", a, b);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("lane_a", a, e.a);
            chk("lane_b", b, e.b);
         end
      end
   end

   initial begin
      int dcnt;
      hand_tab[0] = '{pk(1, 0, 0, 0),    pk(1, 0, 0, 0)};
      hand_tab[1] = '{pk(2, 5, 0, 0),    pk(0, 0, 0, 0)};
      hand_tab[2] = '{pk(3, 6, 9, 0),    pk(0, 1, 0, 0)};
      hand_tab[3] = '{pk(4, 7, 10, 13),  pk(0, 0, 0, 0)};
      hand_tab[4] = '{pk(0, 8, 11, 14),  pk(0, 0, 1, 0)};
      hand_tab[5] = '{pk(0, 0, 12, 15),  pk(0, 0, 0, 0)};
      hand_tab[6] = '{pk(0, 0, 0, 16),   pk(0, 0, 0, 1)};
      rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0;
      start = 1'b0; n_dim = '0; k_dim = '0; m_dim = '0;
      clear_shadow();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset after random writes clears outputs and storage.
      for (int r = 0; r < 4; r++) wr(1'(r & 1), r, {$urandom, $urandom});
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a", a, 64'd0);
      chk("rst_b", b, 64'd0);
      chk("rst_flags", {60'b0, valid, clr, busy, done}, 64'd0);
      rst_n = 1'b1;
      clear_shadow();
      run(3, 3, 3, 1'b0, 1'b0);

      // Full 4x4x4 run, B = identity, hand-computed lanes.
      for (int i = 0; i < 4; i++) begin
         wr(1'b0, i, pk(4*i + 1, 4*i + 2, 4*i + 3, 4*i + 4));
         wr(1'b1, i, pk(i == 0, i == 1, i == 2, i == 3));
      end
      run(3, 3, 3, 1'b1, 1'b0);

      // Reduced dims with arbitrary data.
      for (int i = 0; i < 4; i++) begin
         wr(1'b0, i, pk(16'h100 + 16*i, 16'h101 + 16*i, 16'h102 + 16*i, 16'h103 + 16*i));
         wr(1'b1, i, pk(16'h200 + 16*i, 16'h201 + 16*i, 16'h202 + 16*i, 16'h203 + 16*i));
      end
      run(1, 2, 0, 1'b0, 1'b0);

      // Write and restart during FEED are dropped; following run shows storage intact.
      run(3, 3, 3, 1'b0, 1'b1);
      run(3, 3, 3, 1'b0, 1'b0);

      // Reset at feed step t=2 aborts without done.
      for (int t = 0; t < 3; t++) q.push_back('{lane_a(t, 3, 3), lane_b(t, 3, 3)});
      @(negedge clk);
      start = 1'b1; n_dim = 2'd3; k_dim = 2'd3; m_dim = 2'd3;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_valid", {63'b0, valid}, 64'd0);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      dcnt = 0;
      repeat (10) begin
         if (done === 1'b1) dcnt++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(dcnt), 64'd0);
      clear_shadow();
      run(3, 3, 3, 1'b0, 1'b0);

      // B write orientation (row-wise default, column-wise with the macro).
      wr(1'b1, 0, pk(1, 2, 3, 4));
      run(3, 3, 0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
